i2s_rx_deserializer: RTL and testbench
======================================

Name: i2s_rx_deserializer

Overview:
- Upstream stage of the stereo sample FIFO in the I2S-to-SPDIF transmitter.
- Oversamples the external I2S bus (BCLK, LRCLK, SDATA) in the system clock domain and deserializes one left and one right word per frame.
- Pushes each complete pair into the FIFO with a single-cycle write strobe, gated by the FIFO full flag.
- Tracks lock and overflow status for the control logic.

Parameters:
- WORDSIZE, 32, width of each output word; must match the FIFO WORDSIZE.
- MIN_BITS, 16, minimum bits per slot for the slot to be accepted.

Ports:
- clk  input  1  system clock; must be at least 6x BCLK frequency.
- rst  input  1  reset, asynchronous, active-low.
- i2s_bclk  input  1  I2S bit clock, asynchronous to clk.
- i2s_lrclk  input  1  I2S word select; 0 = left, 1 = right.
- i2s_sdata  input  1  I2S serial data, MSB first.
- full  input  1  FIFO full flag.
- write_en  output  1  one-cycle push strobe to the FIFO.
- data_left_out  output  WORDSIZE  left word, valid while write_en=1.
- data_right_out  output  WORDSIZE  right word, valid while write_en=1.
- locked  output  1  high while frame alignment is held.
- overflow  output  1  sticky flag: a pair was dropped because full=1.

Behaviour:
- Reset (rst=0, async): write_en=0, data_*_out=0, locked=0, overflow=0. All synchronizers, counters and shift words are cleared and the FSM returns to SYNC. Reset mid-frame discards any partial words.
- Sync: each of bclk, lrclk and sdata passes through 2 flops (s1, s2). A third flop s3 holds the previous s2 value of bclk.
  - rise = bclk_s2 & ~bclk_s3.
  - All processing happens only on cycles where rise=1, using lrclk_s2 and sdata_s2.
- Channel rule (I2S one-bit delay): a bit sampled at a BCLK rise belongs to the channel given by lr_prev, the lrclk value latched at the previous rise.
  - When lrclk_s2 != lr_prev, the current bit is the LSB of channel lr_prev, and that slot closes after this bit.
- Word assembly:
  - At slot start, the word is zeroed and bitcnt=0.
  - Each bit is written at position WORDSIZE-1-bitcnt while bitcnt<WORDSIZE. Later bits are discarded; bitcnt saturates at WORDSIZE.
  - Short slots are MSB-aligned with zero-filled LSBs.
- FSM states:
  - SYNC: ignores data. On a slot close with lr_prev=1 (right slot ends), go to LEFT and clear the word.
  - LEFT: on slot close, if total bits >= MIN_BITS, latch the left word and go to RIGHT. Otherwise go to SYNC.
  - RIGHT: on slot close with bits >= MIN_BITS, attempt a push and go to LEFT. Otherwise go to SYNC.
- locked=1 in LEFT and RIGHT; locked=0 in SYNC. A slot shorter than MIN_BITS drops the pair and drops lock.
- Push:
  - If full=0 on the cycle of the right-slot close, then on the next clk edge write_en=1 for exactly one cycle. data_left_out/data_right_out are updated on the same edge and hold until the next push.
  - If full=1, write_en stays 0, the pair is dropped and overflow is set. overflow stays set until reset.
- Latency: let k be the clk edge at which s1 first captures BCLK high for the right-slot LSB. write_en is high in the cycle after edge k+2.
- An LRCLK change without a BCLK rise has no effect. Consecutive pushes are at least 2*MIN_BITS BCLK periods apart.

Test Plan:
- Lock:
  - Stimulus: reset, then 3 frames of 32-bit slots, L=0x12345678 / R=0x9ABCDEF0, then L=0xDEADBEEF / R=0x01020304.
  - Required: first frame dropped while in SYNC; write_en pulses once per later frame with exact words; locked=1 after the first right-slot close.
- 24-bit slots:
  - Stimulus: L=0xABCDEF, R=0x123456.
  - Required: data_left_out=0xABCDEF00, data_right_out=0x12345600; exactly one push per frame.
- Overflow:
  - Stimulus: hold full=1 during one right-slot close.
  - Required: no write_en for that frame; overflow=1 and stays 1; the next frame pushes normally after full=0.
- Short slot:
  - Stimulus: an 8-bit left slot mid-stream.
  - Required: locked falls to 0 and no push for that frame; lock reacquires after the next right slot; pushes resume with correct words.
- Latency:
  - Stimulus: clk 100 MHz, BCLK 3.072 MHz.
  - Required: write_en is high exactly in the cycle after edge k+2 relative to the first s1 capture of the right-LSB BCLK rise.
- Reset mid-frame:
  - Stimulus: assert rst halfway through a left slot.
  - Required: all outputs 0 immediately (asynchronous); no push until a full SYNC→LEFT→RIGHT sequence completes.

Source files
------------

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: oversamples BCLK/LRCLK/SDATA in the clk domain,
// assembles left/right words and pushes each pair to the FIFO.
module i2s_rx_deserializer #(
  parameter int WORDSIZE = 32,
  parameter int MIN_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i2s_bclk,
  input  logic                i2s_lrclk,
  input  logic                i2s_sdata,
  input  logic                full,
  output logic                write_en,
  output logic [WORDSIZE-1:0] data_left_out,
  output logic [WORDSIZE-1:0] data_right_out,
  output logic                locked,
  output logic                overflow
);

  localparam int CW = $clog2(WORDSIZE + 1);
  localparam logic [WORDSIZE-1:0] TOP =
    {1'b1, {(WORDSIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    SYNC,
    LEFT,
    RIGHT
  } state_e;

  state_e state_q, state_d;

  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lr_s1_q, lr_s2_q;
  logic sd_s1_q, sd_s2_q;

  logic                lr_prev_q, lr_prev_d;
  logic [WORDSIZE-1:0] word_q, word_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WORDSIZE-1:0] left_q, left_d;
  logic [WORDSIZE-1:0] dl_q, dl_d;
  logic [WORDSIZE-1:0] dr_q, dr_d;
  logic                we_q, we_d;
  logic                ovf_q, ovf_d;

  logic                rise;
  logic                close;
  logic                long_ok;
  logic [WORDSIZE-1:0] msk;
  logic [WORDSIZE-1:0] word_bit;
  logic [CW-1:0]       cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_s3_q <= 1'b0;
      lr_s1_q   <= 1'b0;
      lr_s2_q   <= 1'b0;
      sd_s1_q   <= 1'b0;
      sd_s2_q   <= 1'b0;
    end else begin
      bclk_s1_q <= i2s_bclk;
      bclk_s2_q <= bclk_s1_q;
      bclk_s3_q <= bclk_s2_q;
      lr_s1_q   <= i2s_lrclk;
      lr_s2_q   <= lr_s1_q;
      sd_s1_q   <= i2s_sdata;
      sd_s2_q   <= sd_s1_q;
    end
  end

  // Mask walks off the word once bitcnt saturates, dropping extra bits.
  always_comb begin
    rise     = bclk_s2_q & ~bclk_s3_q;
    close    = rise & (lr_s2_q != lr_prev_q);
    msk      = TOP >> cnt_q;
    word_bit = word_q | (sd_s2_q ? msk : '0);
    if (cnt_q == CW'(WORDSIZE)) begin
      cnt_inc = cnt_q;
    end else begin
      cnt_inc = cnt_q + 1'b1;
    end
    long_ok  = cnt_inc >= CW'(MIN_BITS);
  end

  always_comb begin
    state_d   = state_q;
    lr_prev_d = lr_prev_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    dl_d      = dl_q;
    dr_d      = dr_q;
    we_d      = 1'b0;
    ovf_d     = ovf_q;
    if (rise) begin
      lr_prev_d = lr_s2_q;
      word_d    = word_bit;
      cnt_d     = cnt_inc;
      if (close) begin
        word_d = '0;
        cnt_d  = '0;
        unique case (state_q)
          SYNC: begin
            if (lr_prev_q) state_d = LEFT;
          end
          LEFT: begin
            if (long_ok) begin
              left_d  = word_bit;
              state_d = RIGHT;
            end else begin
              state_d = SYNC;
            end
          end
          RIGHT: begin
            if (long_ok) begin
              state_d = LEFT;
              if (full) begin
                ovf_d = 1'b1;
              end else begin
                we_d = 1'b1;
                dl_d = left_q;
                dr_d = word_bit;
              end
            end else begin
              state_d = SYNC;
            end
          end
          default: state_d = SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SYNC;
      lr_prev_q <= 1'b0;
      word_q    <= '0;
      cnt_q     <= '0;
      left_q    <= '0;
      dl_q      <= '0;
      dr_q      <= '0;
      we_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lr_prev_q <= lr_prev_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      dl_q      <= dl_d;
      dr_q      <= dr_d;
      we_q      <= we_d;
      ovf_q     <= ovf_d;
    end
  end

  assign write_en       = we_q;
  assign data_left_out  = dl_q;
  assign data_right_out = dr_q;
  assign locked         = (state_q != SYNC);
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: slot-level I2S driver with a
// frame-level model of expected pushes, lock and overflow.
module tb_i2s_rx_deserializer;

  localparam int WS   = 32;
  localparam int MINB = 16;
  localparam int HLO  = 162;
  localparam int HHI  = 164;

  logic          clk = 1'b0;
  logic          rst;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          full;
  logic          write_en;
  logic          locked;
  logic          overflow;
  logic [WS-1:0] dl;
  logic [WS-1:0] dr;

  i2s_rx_deserializer #(
    .WORDSIZE(WS),
    .MIN_BITS(MINB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i2s_bclk      (bclk),
    .i2s_lrclk     (lrclk),
    .i2s_sdata     (sdata),
    .full          (full),
    .write_en      (write_en),
    .data_left_out (dl),
    .data_right_out(dr),
    .locked        (locked),
    .overflow      (overflow)
  );

  // 10-unit clk; BCLK edges land on even times, posedges on odd.
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] l;
    logic [31:0] r;
  } push_t;

  push_t       q[$];
  push_t       hd;
  int          n_pass  = 0;
  int          n_tot   = 0;
  int          cyc     = 0;
  int          evt_cyc = 0;
  bit          m_aligned;
  bit          m_have_l;
  bit          m_ovf;
  logic [31:0] m_l;
  logic [31:0] out_l;
  logic [31:0] out_r;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t",
                  nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_aligned = 1'b0;
    m_have_l  = 1'b0;
    m_ovf     = 1'b0;
    m_l       = '0;
    out_l     = '0;
    out_r     = '0;
    evt_cyc   = cyc;
    q.delete();
  endtask

  // Frame-level rules: a right close aligns; short slots unalign;
  // an aligned left+right pair of legal length is pushed or dropped.
  task automatic slot_closed(input bit c, input int n,
                             input logic [31:0] w);
    evt_cyc = cyc;
    if (!m_aligned) begin
      if (c) m_aligned = 1'b1;
      m_have_l = 1'b0;
    end else if (n < MINB) begin
      m_aligned = 1'b0;
      m_have_l  = 1'b0;
    end else if (!c) begin
      m_l      = w;
      m_have_l = 1'b1;
    end else begin
      if (m_have_l) begin
        if (full) m_ovf = 1'b1;
        else q.push_back('{cyc + 3, m_l, w});
      end
      m_have_l = 1'b0;
    end
  endtask

  task automatic do_reset_mid();
    rst = 1'b0;
    #2;
    check("rst_we",   64'(write_en), 64'(0));
    check("rst_dl",   64'(dl),       64'(0));
    check("rst_dr",   64'(dr),       64'(0));
    check("rst_lock", 64'(locked),   64'(0));
    check("rst_ovf",  64'(overflow), 64'(0));
    model_reset();
    #98;
    rst = 1'b1;
  endtask

  task automatic send_slot(input bit c, input int n,
                           input logic [63:0] v,
                           input int rst_at);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) begin
      bit b;
      b = v[6'(n - 1 - i)];
      if (i < WS) w[5'(WS - 1 - i)] = b;
      bclk  = 1'b0;
      lrclk = (i == n - 1) ? ~c : c;
      sdata = b;
      if (i == rst_at) do_reset_mid();
      #HLO;
      bclk = 1'b1;
      if (i == n - 1) slot_closed(c, n, w);
      #HHI;
    end
  endtask

  task automatic frame(input logic [63:0] vl, input int nl,
                       input logic [63:0] vr, input int nr);
    send_slot(1'b0, nl, vl, -1);
    send_slot(1'b1, nr, vr, -1);
  endtask

  function automatic int pick_len();
    if ($urandom_range(0, 7) == 0) return $urandom_range(4, 15);
    return $urandom_range(16, 34);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      if (write_en) begin
        if (q.size() == 0) begin
          check("spurious_push", 64'(write_en), 64'(0));
        end else begin
          hd = q.pop_front();
          check("push_cyc", 64'(cyc), 64'(hd.cyc));
          check("push_l",   64'(dl),  64'(hd.l));
          check("push_r",   64'(dr),  64'(hd.r));
          out_l = hd.l;
          out_r = hd.r;
        end
      end else begin
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          check("missed_push", 64'(write_en), 64'(1));
          hd = q.pop_front();
        end
        check("hold_l", 64'(dl), 64'(out_l));
        check("hold_r", 64'(dr), 64'(out_r));
      end
      if (cyc >= evt_cyc + 4) begin
        check("locked",   64'(locked),   64'(m_aligned));
        check("overflow", 64'(overflow), 64'(m_ovf));
      end
    end
  end

  initial begin
    rst   = 1'b0;
    bclk  = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    full  = 1'b0;
    model_reset();
    #100;
    check("init_we",   64'(write_en), 64'(0));
    check("init_dl",   64'(dl),       64'(0));
    check("init_dr",   64'(dr),       64'(0));
    check("init_lock", 64'(locked),   64'(0));
    check("init_ovf",  64'(overflow), 64'(0));
    rst = 1'b1;
    #200;

    frame(64'h12345678, 32, 64'h9ABCDEF0, 32);
    check("lock_f1", 64'(locked), 64'(1));
    check("nopush_f1", 64'(dl), 64'(0));
    frame(64'h12345678, 32, 64'h9ABCDEF0, 32);
    check("lit_l1", 64'(dl), 64'h12345678);
    check("lit_r1", 64'(dr), 64'h9ABCDEF0);
    frame(64'hDEADBEEF, 32, 64'h01020304, 32);
    check("lit_l2", 64'(dl), 64'hDEADBEEF);
    check("lit_r2", 64'(dr), 64'h01020304);

    frame(64'hABCDEF, 24, 64'h123456, 24);
    check("lit_l24", 64'(dl), 64'hABCDEF00);
    check("lit_r24", 64'(dr), 64'h12345600);

    full = 1'b1;
    frame(64'h11112222, 32, 64'h33334444, 32);
    full = 1'b0;
    check("ovf_set", 64'(overflow), 64'(1));
    check("ovf_hold_l", 64'(dl), 64'hABCDEF00);
    frame(64'h55556666, 32, 64'h77778888, 32);
    check("ovf_next_l", 64'(dl), 64'h55556666);
    check("ovf_sticky", 64'(overflow), 64'(1));

    send_slot(1'b0, 8, 64'hA5, -1);
    check("short_unlock", 64'(locked), 64'(0));
    send_slot(1'b1, 32, 64'hCAFEF00D, -1);
    check("short_relock", 64'(locked), 64'(1));
    check("short_nopush", 64'(dl), 64'h55556666);
    frame(64'h0BADCAFE, 32, 64'hFEEDFACE, 32);
    check("short_l", 64'(dl), 64'h0BADCAFE);
    check("short_r", 64'(dr), 64'hFEEDFACE);

    send_slot(1'b0, 32, 64'h13579BDF, 16);
    send_slot(1'b1, 32, 64'h2468ACE0, -1);
    check("rst_relock", 64'(locked), 64'(1));
    check("rst_nopush", 64'(dl), 64'(0));
    frame(64'hC001D00D, 32, 64'h600DF00D, 32);
    check("rst_l", 64'(dl), 64'hC001D00D);
    check("rst_r", 64'(dr), 64'h600DF00D);

    for (int f = 0; f < 16; f++) begin
      int nl;
      int nr;
      nl   = pick_len();
      nr   = pick_len();
      full = ($urandom_range(0, 3) == 0);
      send_slot(1'b0, nl, {$urandom, $urandom}, -1);
      send_slot(1'b1, nr, {$urandom, $urandom}, -1);
    end
    full = 1'b0;
    frame({$urandom, $urandom}, 32, {$urandom, $urandom}, 32);
    frame({$urandom, $urandom}, 32, {$urandom, $urandom}, 32);
    #1000;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
